prio_encoder_8x3_q: RTL
=======================

// Module: prio_encoder_8x3_q
// PURPOSE
// - Registered 8-to-3 priority encoder; inverse of the 3x8 decoder.
// - Captures 1-cycle event pulses on an 8-bit request vector into a pending register.
// - Drains pending events one at a time as 3-bit binary codes over a valid/ready handshake.
// - Highest index has highest priority.
// - Sits between event sources and a consumer that services events serially.
// PARAMETERS
// - N_IN    8   number of request inputs
// - CODE_W  3   code width; must equal $clog2(N_IN)
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous reset, active-low
// - req_in       in   N_IN    event pulses; bit i = event i, sampled every edge
// - ready_in     in   1       consumer accepts code_out when valid_out=1
// - code_out     out  CODE_W  binary index of the granted event
// - valid_out    out  1       code_out holds an unconsumed event
// - pending_out  out  N_IN    events captured but not yet granted
// - drop_out     out  1       (ENC_DROP_DETECT_EN only) 1-cycle pulse, event merged
// - drop_cnt     out  8       (ENC_DROP_DETECT_EN only) saturating merged-event count
// BEHAVIOUR
// - Reset (rst_n=0, async, any time):
//   - code_out=0, valid_out=0, pending_out=0, drop_out=0, drop_cnt=0.
//   - req_in is ignored while reset is asserted.
//   - Mid-drain reset discards all pending events and the in-flight code.
// - Candidate set C = pending_out | req_in.
//   - A request can be granted in the same edge it arrives.
//   - Latency req_in -> valid_out is 1 cycle.
// - load = !valid_out || ready_in. On each edge with load=1:
//   - C != 0: valid_out<=1, code_out<=index of the highest set bit of C.
//     pending_out <= C with that bit cleared.
//   - C == 0: valid_out<=0, code_out holds its last value, pending_out<=0.
// - Edge with load=0 (valid_out=1, ready_in=0, stall):
//   - code_out and valid_out hold stable.
//   - pending_out <= pending_out | req_in.
// - Transfer = valid_out && ready_in at an edge.
//   - Back-to-back transfers give one code per cycle.
// - Merge rule:
//   - A req_in bit already set in pending_out coalesces into one event.
//   - A bit currently in code_out is a distinct event and is set in pending_out.
// - Simultaneous req_in bits are all captured and drained in descending index order.
// - Starvation is allowed: a continuously re-requested high index blocks lower ones.
// - Width rule: code_out = CODE_W-bit unsigned index 0..N_IN-1; no wrap or sign.
// CONFIGURATION
// - Macro ENC_DROP_DETECT_EN.
// - Defined:
//   - drop_out, drop_cnt ports exist.
//   - drop_out<=1 for one cycle when (req_in & pending_out) != 0 at an edge.
//   - drop_cnt increments by 1 per such edge and saturates at 255.
//   - Both reset to 0.
// - Undefined:
//   - Ports and logic are absent; merges are silent.
//   - All other behaviour is identical.
// TESTING
// - Reset: rst_n=0, req_in=8'hFF, ready_in=1 -> valid_out=0, code_out=0, pending_out=0.
//   - Release -> no output until a new req_in.
// - Single: ready_in=1, req_in=8'b0000_0100 for one cycle.
//   - Next edge: valid_out=1, code_out=3'd2.
//   - Following edge: valid_out=0.
// - Priority drain: ready_in=1, req_in=8'hA5 for one cycle.
//   - code_out=7,5,2,0 on 4 consecutive cycles.
//   - Then valid_out=0, pending_out=0.
// - Backpressure: ready_in=0, req_in=8'h10 then 8'h80.
//   - code_out=4 held, pending_out=8'h80.
//   - ready_in=1 -> code_out=7 next cycle, then valid_out=0.
// - Drop (macro on): with pending bit 3 set, pulse req_in=8'h08 -> drop_out one-cycle pulse, drop_cnt=1.
//   - Force 300 merges -> drop_cnt=255.
// - Round trip: drive decoder_3x8 with i=0..7; pulse its output into req_in, ready_in=1.
//   - code_out equals i each time.

Source files
------------

// File: rtl/prio_encoder_8x3_q_if.sv
// prio_encoder_8x3_q_if: request/grant bus between event sources, the encoder and its consumer.
// The drop_out/drop_cnt signals exist only when ENC_DROP_DETECT_EN is defined.
interface prio_encoder_8x3_q_if #(
  parameter int N_IN   = 8,
  parameter int CODE_W = 3
);
  logic [N_IN-1:0]   req_in;
  logic              ready_in;
  logic [CODE_W-1:0] code_out;
  logic              valid_out;
  logic [N_IN-1:0]   pending_out;
`ifdef ENC_DROP_DETECT_EN
  logic              drop_out;
  logic [7:0]        drop_cnt;
`endif

  modport master (
    output req_in,
    output ready_in,
    input  code_out,
    input  valid_out,
`ifdef ENC_DROP_DETECT_EN
    input  drop_out,
    input  drop_cnt,
`endif
    input  pending_out
  );

  modport slave (
    input  req_in,
    input  ready_in,
    output code_out,
    output valid_out,
`ifdef ENC_DROP_DETECT_EN
    output drop_out,
    output drop_cnt,
`endif
    output pending_out
  );
endinterface

// File: rtl/prio_encoder_8x3_q.sv
// prio_encoder_8x3_q: captures event pulses and drains them highest-index-first as codes
// over valid/ready. Define ENC_DROP_DETECT_EN to add the merge pulse and saturating count.
module prio_encoder_8x3_q #(
  parameter int N_IN   = 8,
  parameter int CODE_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  prio_encoder_8x3_q_if.slave bus
);
  logic [N_IN-1:0]   pending_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [N_IN-1:0]   cand;
  logic              cand_any;
  logic              load;
  logic [CODE_W-1:0] top_idx;
  logic [N_IN-1:0]   top_mask;

  assign cand     = pending_q | bus.req_in;
  assign cand_any = |cand;
  assign load     = !valid_q || bus.ready_in;

  // Ascending scan: the highest set candidate is the last one written, so it wins.
  always_comb begin
    top_idx  = '0;
    top_mask = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (cand[i]) begin
        top_idx     = CODE_W'(i);
        top_mask    = '0;
        top_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      code_q    <= '0;
      pending_q <= '0;
    end else if (load) begin
      if (cand_any) begin
        valid_q   <= 1'b1;
        code_q    <= top_idx;
        pending_q <= cand & ~top_mask;
      end else begin
        valid_q   <= 1'b0;
        pending_q <= '0;
      end
    end else begin
      // Stalled: the presented code stays put, new pulses still accumulate.
      pending_q <= pending_q | bus.req_in;
    end
  end

  assign bus.code_out    = code_q;
  assign bus.valid_out   = valid_q;
  assign bus.pending_out = pending_q;

`ifdef ENC_DROP_DETECT_EN
  logic       drop_q;
  logic [7:0] drop_cnt_q;
  logic       merge;

  // A pulse on a bit that is already pending collapses into the existing event.
  assign merge = |(bus.req_in & pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= merge;
      if (merge && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.drop_out = drop_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule
